// File: rtl/mcd_pkg.sv
// Shared definitions for the multi-channel clock divider.
package mcd_pkg;

  localparam int unsigned DIV_MIN = 1;

  typedef enum logic [0:0] {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcd_if.sv
// Config port of the multi-channel clock divider: one valid/ready request carrying channel and
// half-period.
interface mcd_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
);
  import mcd_pkg::*;

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/mcd_channel.sv
// One divider channel: half-period counter, divide register, registered clk_out and tick.
// The parent decides when a new divide value may be loaded.
module mcd_channel
  import mcd_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             apply_ok,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_eff;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             terminal;
  ch_state_e        state;

  always_comb begin
    state    = en ? CH_RUN : CH_IDLE;
    // A zero divide behaves as one: toggle every cycle.
    div_eff  = (div_q < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : div_q;
    terminal = (state == CH_RUN) && (cnt_q == div_eff - CNT_W'(1));
    // Loads happen only on a half-period boundary or while stopped, never during a sync.
    apply_ok = !sync && (terminal || (state == CH_IDLE));

    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    div_d  = load ? load_div : div_q;

    if (sync) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else begin
      unique case (state)
        CH_IDLE: begin
          cnt_d = '0;
          clk_d = 1'b0;
        end
        CH_RUN: begin
          if (terminal) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
          clk_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH-channel programmable clock divider with a single-slot config port.
// Define MCD_SYNC_EN to add the sync_all phase-alignment input.
module multi_clock_divider
  import mcd_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  mcd_if.slave              cfg,
`ifdef MCD_SYNC_EN
  input  logic              sync_all,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic              pend_q, pend_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic [NUM_CH-1:0] apply_ok;
  logic [NUM_CH-1:0] load;
  logic              ch_bad;
  logic              accept;
  logic              sync;

`ifdef MCD_SYNC_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif

  assign cfg.cfg_ready = ~pend_q;
  assign accept        = cfg.cfg_valid & ~pend_q;
  assign ch_bad        = 32'(pend_ch_q) >= NUM_CH;

  always_comb begin
    load = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (pend_q && !ch_bad && (pend_ch_q == CH_W'(i))) begin
        load[i] = apply_ok[i];
      end
    end
  end

  always_comb begin
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    // Out-of-range targets are accepted and silently dropped.
    if (pend_q && (ch_bad || (|load))) begin
      pend_d = 1'b0;
    end
    if (accept) begin
      pend_d     = 1'b1;
      pend_ch_d  = cfg.cfg_ch;
      pend_div_d = cfg.cfg_div;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    mcd_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (ch_en[g]),
      .sync     (sync),
      .load     (load[g]),
      .load_div (pend_div_q),
      .apply_ok (apply_ok[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider: a toggle-time reference model predicts
// {cfg_ready, tick, clk_out} per cycle; a monitor compares on the falling edge.
module tb_multi_clock_divider;
  import mcd_pkg::*;

  localparam int unsigned NUM_CH      = 5;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DEFAULT_DIV = 4;
  localparam int unsigned CH_W        = ch_width(NUM_CH);
  localparam int unsigned OW          = 2 * NUM_CH + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              sync_all;

  mcd_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg ();

  multi_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_en    (ch_en),
    .cfg      (cfg),
`ifdef MCD_SYNC_EN
    .sync_all (sync_all),
`endif
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Reference model: each running channel knows the absolute edge of its next toggle.
  int unsigned m_div [NUM_CH];
  bit          m_lvl [NUM_CH];
  bit          m_run [NUM_CH];
  longint      m_tog [NUM_CH];
  bit          m_pv;
  int unsigned m_pch;
  int unsigned m_pdiv;
  bit          m_acc;
  longint      k = 0;

  logic [OW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic longint eff(int unsigned d);
    return (d == 0) ? 64'd1 : longint'(d);
  endfunction

  function automatic void model();
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] lv;
    bit pv0;
    bit done;
    tk    = '0;
    lv    = '0;
    pv0   = m_pv;
    done  = 1'b0;
    m_acc = 1'b0;
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        m_div[i] = DEFAULT_DIV;
        m_lvl[i] = 1'b0;
        m_run[i] = 1'b0;
      end
      m_pv = 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (sync_all) begin
          m_lvl[i] = 1'b0;
          m_run[i] = 1'b0;
        end else if (!ch_en[i]) begin
          m_lvl[i] = 1'b0;
          m_run[i] = 1'b0;
          if (pv0 && m_pch == i) begin
            m_div[i] = m_pdiv;
            done     = 1'b1;
          end
        end else begin
          if (!m_run[i]) begin
            m_run[i] = 1'b1;
            m_tog[i] = k + eff(m_div[i]) - 1;
          end
          if (m_tog[i] == k) begin
            m_lvl[i] = !m_lvl[i];
            tk[i]    = m_lvl[i];
            if (pv0 && m_pch == i) begin
              m_div[i] = m_pdiv;
              done     = 1'b1;
            end
            m_tog[i] = k + eff(m_div[i]);
          end
        end
      end
      if (pv0 && (done || m_pch >= NUM_CH)) m_pv = 1'b0;
      if (cfg.cfg_valid && !pv0) begin
        m_pv   = 1'b1;
        m_pch  = int'(cfg.cfg_ch);
        m_pdiv = int'(cfg.cfg_div);
        m_acc  = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) lv[i] = m_lvl[i];
    k++;
    exp_q.push_back({~m_pv, tk, lv});
  endfunction

  task automatic step(output bit accepted);
    @(posedge clk);
    model();
    accepted = m_acc;
    #1;
  endtask

  task automatic cycles(input int n);
    bit a;
    repeat (n) step(a);
  endtask

  // Leaves cfg_valid asserted so callers can issue back-to-back requests.
  task automatic cfg_write(input int unsigned ch, input int unsigned div);
    bit a;
    bit ok;
    ok            = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = CH_W'(ch);
    cfg.cfg_div   = CNT_W'(div);
    for (int t = 0; t < 300; t++) begin
      step(a);
      if (a) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg_accept ch=%0d: not accepted within 300 cycles, required acceptance", ch);
    end
  endtask

  // Monitor: DUT outputs are presented every cycle; compare against the queued prediction.
  initial begin
    logic [OW-1:0] e;
    logic [OW-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {cfg.cfg_ready, tick, clk_out};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t {ready,tick,clk_out}: got %b required %b", $time, a, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    ch_en         = '0;
    sync_all      = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_div   = '0;
    cycles(2);
    reset = 1'b0;

    // Default divide on channel 0.
    ch_en = NUM_CH'(1);
    cycles(40);

    // Reprogram a running channel mid-phase.
    cycles(1);
    cfg_write(0, 2);
    cfg.cfg_valid = 1'b0;
    cycles(30);

    // Zero divide on an idle channel, then enable it.
    cfg_write(1, 0);
    cfg.cfg_valid = 1'b0;
    cycles(3);
    ch_en[1] = 1'b1;
    cycles(12);

    // Back-to-back requests for two running channels.
    ch_en[3:2] = 2'b11;
    cycles(5);
    cfg_write(2, 3);
    cfg_write(3, 5);
    cfg.cfg_valid = 1'b0;
    cycles(40);

    // Out-of-range channel is dropped.
    cfg_write(6, 1);
    cfg.cfg_valid = 1'b0;
    cycles(6);

    // Reset while a request is pending.
    ch_en[4] = 1'b1;
    cycles(3);
    cfg_write(4, 9);
    cfg.cfg_valid = 1'b0;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(30);

`ifdef MCD_SYNC_EN
    ch_en = NUM_CH'(3);
    cfg_write(0, 3);
    cfg_write(1, 5);
    cfg.cfg_valid = 1'b0;
    cycles(23);
    sync_all = 1'b1;
    cycles(1);
    sync_all = 1'b0;
    cycles(20);
`endif

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      bit a;
      if ($urandom_range(15) == 0) ch_en[$urandom_range(NUM_CH - 1)] ^= 1'b1;
      cfg.cfg_valid = ($urandom_range(5) == 0);
      cfg.cfg_ch    = CH_W'($urandom_range(NUM_CH + 1));
      cfg.cfg_div   = CNT_W'($urandom_range(6));
`ifdef MCD_SYNC_EN
      sync_all = ($urandom_range(39) == 0);
`endif
      reset = ($urandom_range(499) == 0);
      step(a);
    end
    reset         = 1'b0;
    sync_all      = 1'b0;
    cfg.cfg_valid = 1'b0;
    cycles(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
